// File: rtl/step_pulser_pkg.sv
// Shared FSM state type and default pulse timing for the step pulse generator.
package step_pulser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_e;

  localparam int DEF_PW  = 2;
  localparam int DEF_GAP = 2;

endpackage

// File: rtl/step_pulser_wrap_delta.sv
// Unsigned modulo-2^HW phase difference between the new and previous coarse phase.
module wrap_delta #(
  parameter int HW = 12
) (
  input  logic [HW-1:0] cur_i,
  input  logic [HW-1:0] prev_i,
  output logic [HW-1:0] delta_o
);

  // Truncation to HW bits gives the wrap-around for free (4094 -> 2 yields 4).
  assign delta_o = cur_i - prev_i;

endmodule

// File: rtl/step_pulser.sv
// Converts coarse phase advances into a train of fixed-width step pulses,
// queuing pending steps in a saturating counter.
module step_pulser
  import step_pulser_pkg::*;
#(
  parameter int HW  = 12,
  parameter int PNW = 16,
  parameter int PW  = DEF_PW,
  parameter int GAP = DEF_GAP
) (
  input  logic           C,
  input  logic           R,
  input  logic [HW-1:0]  h,
  input  logic           hv,
  output logic           step,
  output logic           busy,
  output logic [PNW-1:0] pend,
  output logic           ovf
);

  localparam int CMAX = (PW > GAP) ? PW : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int SW   = PNW + HW + 1;

  localparam logic [CW-1:0] PW_LOAD  = CW'(PW - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);
  localparam logic [SW-1:0] PEND_MAX = {{(SW-PNW){1'b0}}, {PNW{1'b1}}};

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           step_q;
  logic           busy_q;
  logic [PNW-1:0] pend_q;
  logic [PNW-1:0] pend_d;
  logic           ovf_q;
  logic           ovf_d;
  logic [HW-1:0]  h_prev_q;
  logic           primed_q;
  logic [HW-1:0]  raw_delta;
  logic [HW-1:0]  add_delta;
  logic           start_pulse;
  logic [SW-1:0]  pend_sum;

  wrap_delta #(
    .HW(HW)
  ) u_wrap_delta (
    .cur_i  (h),
    .prev_i (h_prev_q),
    .delta_o(raw_delta)
  );

  // The first valid phase after reset only establishes a reference point.
  assign add_delta = (hv && primed_q) ? raw_delta : '0;

  assign start_pulse = (pend_q != '0) &&
                       ((state_q == IDLE) || ((state_q == LO) && (cnt_q == '0)));

  always_comb begin
    pend_sum = SW'(pend_q) + SW'(add_delta) - SW'(start_pulse);
    pend_d   = pend_sum[PNW-1:0];
    ovf_d    = ovf_q;
    if (pend_sum > PEND_MAX) begin
      pend_d = '1;
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      h_prev_q <= '0;
      primed_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (hv) begin
        h_prev_q <= h;
        primed_q <= 1'b1;
      end
    end
  end

  // step and busy are registered alongside the state so they never glitch.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            state_q <= HI;
            cnt_q   <= PW_LOAD;
            step_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HI: begin
          if (cnt_q == '0) begin
            state_q <= LO;
            cnt_q   <= GAP_LOAD;
            step_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LO: begin
          if (cnt_q == '0) begin
            if (start_pulse) begin
              state_q <= HI;
              cnt_q   <= PW_LOAD;
              step_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign step = step_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule
